dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle, handshaked data-memory responder that serves the load/store requests issued by the RISC-V core's memory stage. It accepts one request at a time, inserts a configurable number of wait states, performs a little-endian byte/half/word access, and returns load data with LB/LH/LW/LBU/LHU extension already applied. It is the target end of the core's data-memory interface, used once the core moves from a zero-latency memory to a stalling one.

## Interface
- N, 32: data width in bits; byte lanes = N/8.
- MEM_ADDR, 8: byte-address width; storage is 2^MEM_ADDR bytes.
- WAIT_STATES, 2: cycles spent in WAIT between accept and response, 0..15.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- addr  in  MEM_ADDR  byte address.
- wdata  in  N  store data, LSB-aligned.
- mem_read  in  3  000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 110/111 reserved.
- mem_write  in  2  00 none, 01 SB, 10 SH, 11 SW.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes response.
- rdata  out  N  extended load data; 0 for stores and no-ops.
- rsp_err  out  1  access fault (only meaningful with MISALIGN_TRAP_EN).

## Operation
- FSM: IDLE -> WAIT -> RESP -> IDLE.
- IDLE: req_ready=1. On req_valid: latch addr, wdata, mem_read, mem_write. Go to WAIT, or to RESP directly if WAIT_STATES=0.
- WAIT: 4-bit counter counts down from WAIT_STATES-1. On reaching 0, perform the access and go to RESP.
- RESP: rsp_valid=1, and rdata/rsp_err stay stable. On rsp_ready, go to IDLE.
- Access is performed once, on the transition into RESP; stores commit to storage on that edge.
- Byte lane k of an access uses address (addr+k) mod 2^MEM_ADDR, so accesses wrap around the top of memory. Layout is little-endian.
- Loads: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW returns 4 bytes.
- mem_write != 00 wins over mem_read. Such a request is a store, and rdata=0.
- Both encodings zero, or reserved mem_read: no-op with rdata=0, still handshaked.
- Only one request is outstanding; req_valid outside IDLE is ignored.

## Timing
- Reset (rst=0, async): state=IDLE, counter=0, req_ready=1, rsp_valid=0, rdata=0, rsp_err=0, all storage bytes=0.
- Accept edge T (req_valid & req_ready) -> rsp_valid rises after edge T+WAIT_STATES+1 clocks. With WAIT_STATES=0, rsp_valid is high in the cycle after accept.
- rsp_valid, rdata and rsp_err are registered outputs. There is no combinational path from any input to them.
- req_ready is a registered state decode. It is low from the edge after accept until the edge on which rsp_ready is seen in RESP.
- Back-to-back: the next request can be accepted on the cycle after the RESP handshake. Minimum throughput is one access per WAIT_STATES+2 cycles.
- Reset during WAIT aborts the request; a pending store does not commit.
- Reset during RESP drops the response; a store already committed is then cleared by the storage reset.
- rsp_ready held high ahead of time is legal; the handshake completes in the first RESP cycle.

## Configuration
- MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]!=0, LW/SW with addr[1:0]!=0, or a reserved mem_read code give a fault response.
  - Fault response: rsp_err=1, rdata=0, and no storage write.
  - rsp_err is 0 on all other responses.
- MISALIGN_TRAP_EN undefined: misaligned accesses proceed byte-wise with wrap-around, reserved codes are no-ops, and rsp_err is tied to 0.

## Test plan
- Reset, then SW addr=0x10 wdata=0xDEADBEEF; then LW addr=0x10 -> rdata=0xDEADBEEF, rsp_valid exactly WAIT_STATES+1 cycles after each accept.
- After the above: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB addr=0x11 wdata=0x55, then LW 0x10 -> 0xDEAD55EF. Hold rsp_ready=0 for 5 cycles on the load -> rsp_valid and rdata held, req_ready=0 throughout.
- SW addr=0xFE wdata=0x11223344, macro off -> LBU 0xFE=0x44, 0xFF=0x33, 0x00=0x22, 0x01=0x11. Macro on -> rsp_err=1 and bytes unchanged.
- Assert rst=0 mid-WAIT of SW addr=0x20 wdata=0xA5A5A5A5 -> outputs return to reset values at once; a later LW 0x20 returns 0.
- WAIT_STATES=0 build: SW then LW back-to-back with rsp_ready=1 -> one access every 2 cycles, correct data.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Multi-cycle, handshaked data-memory target for the core's memory stage.
//   One request is accepted at a time in IDLE. The responder then spends
//   WAIT_STATES cycles in WAIT, performs a little-endian byte/half/word access
//   on the transition into RESP, and holds a registered response until the
//   requester takes it.
//
//   Handshake: a request transfers on a rising edge where req_valid and
//   req_ready are both 1; a response transfers on a rising edge where
//   rsp_valid and rsp_ready are both 1. req_ready is 1 only in IDLE and
//   rsp_valid is 1 only in RESP. While a response is pending, rdata and
//   rsp_err do not change. req_valid is ignored outside IDLE. rsp_ready may be
//   held high in advance; the response then completes in its first cycle.
//
//   Optional feature macro: MISALIGN_TRAP_EN
//     defined   : misaligned LH/LHU/SH/LW/SW and reserved load codes return
//                 rsp_err=1, rdata=0, and do not write storage.
//     undefined : misaligned accesses proceed byte-wise with wrap-around,
//                 reserved load codes are no-ops, rsp_err is always 0.
//
//   Parameters
//     N           data width in bits (byte lanes = N/8)
//     MEM_ADDR    byte-address width; storage is 2^MEM_ADDR bytes
//     WAIT_STATES cycles spent in WAIT, 0..15
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous reset, active low
//     req_valid  request present
//     req_ready  responder can accept (IDLE)
//     addr       byte address
//     wdata      store data, LSB-aligned
//     mem_read   000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 11x reserved
//     mem_write  00 none, 01 SB, 10 SH, 11 SW (a store wins over a load)
//     rsp_valid  response present
//     rsp_ready  requester takes response
//     rdata      extended load data, 0 for stores, no-ops and faults
//     rsp_err    access fault
//     state_dbg  current FSM state (0 IDLE, 1 WAIT, 2 RESP)

module dmem_responder #(
    parameter int N           = 32,
    parameter int MEM_ADDR    = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [MEM_ADDR-1:0] addr,
    input  logic [N-1:0]        wdata,
    input  logic [2:0]          mem_read,
    input  logic [1:0]          mem_write,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [N-1:0]        rdata,
    output logic                rsp_err,
    output logic [1:0]          state_dbg
);

    localparam int LANES = N / 8;
    localparam int DEPTH = 1 << MEM_ADDR;

    // Counter reload: WAIT lasts WAIT_STATES cycles, counting down to 0.
    localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [2:0] RD_LB  = 3'b001;
    localparam logic [2:0] RD_LH  = 3'b010;
    localparam logic [2:0] RD_LW  = 3'b011;
    localparam logic [2:0] RD_LBU = 3'b100;
    localparam logic [2:0] RD_LHU = 3'b101;

    localparam logic [1:0] WR_SB = 2'b01;
    localparam logic [1:0] WR_SH = 2'b10;
    localparam logic [1:0] WR_SW = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [3:0]          cnt;
    logic [MEM_ADDR-1:0] addr_q;
    logic [N-1:0]        wdata_q;
    logic [2:0]          read_q;
    logic [1:0]          write_q;

    logic [7:0] mem [DEPTH];

    // Operands of the access. With WAIT_STATES=0 the access happens on the
    // accept edge itself, so it must use the live inputs rather than the
    // latched copies, which are only loaded on that same edge.
    logic [MEM_ADDR-1:0] acc_addr;
    logic [N-1:0]        acc_wdata;
    logic [2:0]          acc_read;
    logic [1:0]          acc_write;

    logic                do_access;
    logic                is_store;
    logic                fault;
    logic [N-1:0]        raw;
    logic [N-1:0]        load_data;
    logic [LANES-1:0]    be;

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES == 0) state_nxt = S_RESP;
                    else                  state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // The access fires exactly once, on the edge that enters RESP.
    assign do_access = (state_nxt == S_RESP) && (state != S_RESP);

    // ------------------------------------------------------------------
    // Access datapath
    // ------------------------------------------------------------------
    always_comb begin
        if (state == S_IDLE) begin
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_read  = mem_read;
            acc_write = mem_write;
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_read  = read_q;
            acc_write = write_q;
        end
    end

    assign is_store = (acc_write != 2'b00);

    // Gather N/8 bytes starting at acc_addr; the index wraps at the top of
    // memory because the sum stays MEM_ADDR bits wide.
    always_comb begin
        raw = '0;
        for (int k = 0; k < LANES; k++) begin
            raw[8*k +: 8] = mem[acc_addr + MEM_ADDR'(k)];
        end
    end

    always_comb begin
        load_data = '0;
        if (!is_store) begin
            case (acc_read)
                RD_LB:   load_data = {{(N-8){raw[7]}}, raw[7:0]};
                RD_LH:   load_data = {{(N-16){raw[15]}}, raw[15:0]};
                RD_LW:   load_data = raw;
                RD_LBU:  load_data = {{(N-8){1'b0}}, raw[7:0]};
                RD_LHU:  load_data = {{(N-16){1'b0}}, raw[15:0]};
                default: load_data = '0;
            endcase
        end
    end

    always_comb begin
        be = '0;
        for (int k = 0; k < LANES; k++) begin
            be[k] = (acc_write == WR_SW) ||
                    ((acc_write == WR_SH) && (k < 2)) ||
                    ((acc_write == WR_SB) && (k == 0));
        end
    end

`ifdef MISALIGN_TRAP_EN
    // A store ignores mem_read entirely, so a reserved load code only
    // faults when no store is requested.
    always_comb begin
        fault = 1'b0;
        if (is_store) begin
            fault = ((acc_write == WR_SH) && acc_addr[0]) ||
                    ((acc_write == WR_SW) && (acc_addr[1:0] != 2'b00));
        end else begin
            fault = (acc_read[2:1] == 2'b11) ||
                    (((acc_read == RD_LH) || (acc_read == RD_LHU)) && acc_addr[0]) ||
                    ((acc_read == RD_LW) && (acc_addr[1:0] != 2'b00));
        end
    end
`else
    assign fault = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else if (do_access && is_store && !fault) begin
            for (int k = 0; k < LANES; k++) begin
                if (be[k]) mem[acc_addr + MEM_ADDR'(k)] <= acc_wdata[8*k +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Request latch, wait counter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            read_q    <= 3'b000;
            write_q   <= 2'b00;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rdata     <= '0;
            rsp_err   <= 1'b0;
        end else begin
            req_ready <= (state_nxt == S_IDLE);
            rsp_valid <= (state_nxt == S_RESP);

            if ((state == S_IDLE) && req_valid) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                read_q  <= mem_read;
                write_q <= mem_write;
                cnt     <= WS_LOAD;
            end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end

            if (do_access) begin
                rdata   <= fault ? '0 : load_data;
                rsp_err <= fault;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Self-checking bench for dmem_responder: directed scenarios followed by
//   randomized requests, all checked against a byte-array reference model.
//   Works with MISALIGN_TRAP_EN defined or undefined; WS selects WAIT_STATES.

module tb_dmem_responder;

    parameter int WS = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  mem_read;
    logic [1:0]  mem_write;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rdata;
    logic        rsp_err;
    logic [1:0]  state_dbg;

    dmem_responder #(
        .N           (32),
        .MEM_ADDR    (8),
        .WAIT_STATES (WS)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .addr      (addr),
        .wdata     (wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rdata     (rdata),
        .rsp_err   (rsp_err),
        .state_dbg (state_dbg)
    );

    // ------------------------------------------------------------------
    // Clock / reset / cycle count
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] exp_q[$];          // {rsp_err, rdata}
    logic [7:0]  ref_mem [256];
    int acc_cyc  = 0;
    int acc_prev = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        exp_q.delete();
    endtask

    // Reference behaviour from the access rules: byte k lives at (a+k) mod 256.
    function automatic logic [32:0] model(input logic [2:0] rd, input logic [1:0] wr,
                                          input logic [7:0] a, input logic [31:0] wd);
        bit err;
        int nbytes;
        int val;
        err = 0;
`ifdef MISALIGN_TRAP_EN
        if (wr != 0) err = (wr == 2 && (a % 2) != 0) || (wr == 3 && (a % 4) != 0);
        else         err = (rd >= 6) || ((rd == 2 || rd == 5) && (a % 2) != 0) ||
                           (rd == 3 && (a % 4) != 0);
`endif
        if (err) return {1'b1, 32'h0};
        if (wr != 0) begin
            nbytes = (wr == 1) ? 1 : (wr == 2) ? 2 : 4;
            for (int i = 0; i < nbytes; i++)
                ref_mem[(int'(a) + i) % 256] = 8'((wd >> (8 * i)) & 32'hFF);
            return 33'h0;
        end
        case (rd)
            1, 4: val = int'(ref_mem[a]);
            2, 5: val = int'(ref_mem[a]) + 256 * int'(ref_mem[(int'(a) + 1) % 256]);
            3: begin
                val = 0;
                for (int i = 3; i >= 0; i--) val = val * 256 + int'(ref_mem[(int'(a) + i) % 256]);
            end
            default: val = 0;
        endcase
        if (rd == 1 && val > 127)   val = val - 256;
        if (rd == 2 && val > 32767) val = val - 65536;
        return {1'b0, 32'(val)};
    endfunction

    // ------------------------------------------------------------------
    // Driver: one full transaction, called and returning at a negedge in IDLE
    // ------------------------------------------------------------------
    task automatic do_req(input logic [2:0] rd, input logic [1:0] wr, input logic [7:0] a,
                          input logic [31:0] wd, input int hold, input bit early,
                          output logic [31:0] got_d, output logic got_e);
        int n;
        logic [32:0] exp;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        exp_q.push_back(model(rd, wr, a, wd));
        acc_prev  = acc_cyc;
        acc_cyc   = cyc;
        rsp_ready = early;
        @(negedge clk);
        if (early) begin
            req_valid = 1'b0;
        end else begin
            // Requests while busy must be ignored.
            req_valid = 1'b1;
            addr      = 8'($urandom);
            wdata     = $urandom;
            mem_read  = 3'b011;
            mem_write = 2'b11;
        end
        n = 1;
        while (!rsp_valid && n < 40) begin
            check("req_ready_busy", req_ready, 0);
            @(negedge clk);
            n++;
        end
        check("latency", n, WS + 1);
        exp = exp_q.pop_front();
        for (int h = 0; h < hold && !early; h++) begin
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rdata, exp[31:0]);
            check("hold_ready", req_ready, 0);
            @(negedge clk);
        end
        got_d = rdata;
        got_e = rsp_err;
        check("rsp_valid", rsp_valid, 1);
        check("rdata", rdata, exp[31:0]);
        check("rsp_err", rsp_err, exp[32]);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", rsp_valid, 0);
        check("ready_back", req_ready, 1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] d;
        logic        e;
        logic [2:0]  r_rd;
        logic [1:0]  r_wr;
        logic [7:0]  r_a;

        rst       = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        addr      = '0;
        wdata     = '0;
        mem_read  = '0;
        mem_write = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        rst = 1'b1;
        @(negedge clk);

        // Word store / load and extension cases
        do_req(3'b000, 2'b11, 8'h10, 32'hDEADBEEF, 0, 0, d, e);
        check("sw_rdata_zero", d, 0);
        do_req(3'b011, 2'b00, 8'h10, 32'h0, 0, 0, d, e);
        check("lw_10", d, 32'hDEADBEEF);
        do_req(3'b001, 2'b00, 8'h13, 32'h0, 0, 0, d, e);
        check("lb_13", d, 32'hFFFFFFDE);
        do_req(3'b100, 2'b00, 8'h13, 32'h0, 0, 0, d, e);
        check("lbu_13", d, 32'h000000DE);
        do_req(3'b010, 2'b00, 8'h10, 32'h0, 0, 0, d, e);
        check("lh_10", d, 32'hFFFFBEEF);
        do_req(3'b101, 2'b00, 8'h12, 32'h0, 0, 0, d, e);
        check("lhu_12", d, 32'h0000DEAD);

        // Byte store, then a load whose response is held off for 5 cycles
        do_req(3'b000, 2'b01, 8'h11, 32'h00000055, 0, 0, d, e);
        do_req(3'b011, 2'b00, 8'h10, 32'h0, 5, 0, d, e);
        check("lw_10_after_sb", d, 32'hDEAD55EF);

        // Misaligned word store across the top of memory
        do_req(3'b000, 2'b11, 8'hFE, 32'h11223344, 0, 0, d, e);
`ifdef MISALIGN_TRAP_EN
        check("sw_fe_err", e, 1);
        do_req(3'b100, 2'b00, 8'hFE, 32'h0, 0, 0, d, e); check("lbu_fe", d, 32'h00);
        do_req(3'b100, 2'b00, 8'hFF, 32'h0, 0, 0, d, e); check("lbu_ff", d, 32'h00);
        do_req(3'b100, 2'b00, 8'h00, 32'h0, 0, 0, d, e); check("lbu_00", d, 32'h00);
        do_req(3'b100, 2'b00, 8'h01, 32'h0, 0, 0, d, e); check("lbu_01", d, 32'h00);
`else
        check("sw_fe_err", e, 0);
        do_req(3'b100, 2'b00, 8'hFE, 32'h0, 0, 0, d, e); check("lbu_fe", d, 32'h44);
        do_req(3'b100, 2'b00, 8'hFF, 32'h0, 0, 0, d, e); check("lbu_ff", d, 32'h33);
        do_req(3'b100, 2'b00, 8'h00, 32'h0, 0, 0, d, e); check("lbu_00", d, 32'h22);
        do_req(3'b100, 2'b00, 8'h01, 32'h0, 0, 0, d, e); check("lbu_01", d, 32'h11);
`endif

        // Back-to-back with rsp_ready held high in advance
        do_req(3'b000, 2'b11, 8'h40, 32'hCAFE0123, 0, 1, d, e);
        do_req(3'b011, 2'b00, 8'h40, 32'h0, 0, 1, d, e);
        check("b2b_spacing", acc_cyc - acc_prev, WS + 2);
        check("b2b_lw_40", d, 32'hCAFE0123);

        // Reset while a store is in flight
        req_valid = 1'b1;
        mem_read  = 3'b000;
        mem_write = 2'b11;
        addr      = 8'h20;
        wdata     = 32'hA5A5A5A5;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_req_ready", req_ready, 1);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_rdata", rdata, 0);
        check("midrst_rsp_err", rsp_err, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_req(3'b011, 2'b00, 8'h20, 32'h0, 0, 0, d, e);
        check("lw_20_after_rst", d, 0);
        do_req(3'b011, 2'b00, 8'h10, 32'h0, 0, 0, d, e);
        check("lw_10_after_rst", d, 0);

        // Randomized traffic around the wrap point and a low window
        for (int i = 0; i < 80; i++) begin
            r_rd = 3'($urandom_range(0, 7));
            r_wr = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            r_a  = ($urandom_range(0, 1) == 0) ? 8'(8'hFC + 8'($urandom_range(0, 7)))
                                               : 8'(8'h10 + 8'($urandom_range(0, 15)));
            do_req(r_rd, r_wr, r_a, $urandom, $urandom_range(0, 3),
                   bit'($urandom_range(0, 3) == 0), d, e);
        end

        check("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
